// File: rtl/cordic_seq.sv
// Folded rotation-mode CORDIC: one shift-add stage reused for ITERS cycles to give cos/sin.
// Optional input quadrant folding is enabled by defining CORDIC_SEQ_QUADRANT_EN.

module iteration #(
  parameter int WIDTH = 23
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  input  logic        [4:0]       shift,
  input  logic        [WIDTH-2:0] angle,
  output logic signed [WIDTH-1:0] x_next,
  output logic signed [WIDTH-1:0] y_next,
  output logic signed [WIDTH-1:0] z_next
);
  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;
  logic signed [WIDTH-1:0] a_ext;

  always_comb begin
    x_sh  = x >>> shift;
    y_sh  = y >>> shift;
    a_ext = {1'b0, angle};
    // Rotate towards z = 0: direction follows the sign of the residual angle.
    if (z[WIDTH-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + a_ext;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - a_ext;
    end
  end
endmodule

module cordic_seq #(
  parameter int FRACS = 21,
  parameter int INTS  = 1,
  parameter int WIDTH = INTS + FRACS + 1,
  parameter int ITERS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    busy
);
  localparam longint ONE60 = longint'(1) <<< 60;

  // atan(2^-s) scaled by 2^60, Taylor series; s >= 1 so it converges.
  function automatic longint atan_pow2(input int s);
    longint acc;
    acc = 0;
    for (int k = 0; s * (2 * k + 1) <= 60; k++) begin
      if (k % 2 == 0) acc = acc + (ONE60 >>> (s * (2 * k + 1))) / longint'(2 * k + 1);
      else            acc = acc - (ONE60 >>> (s * (2 * k + 1))) / longint'(2 * k + 1);
    end
    return acc;
  endfunction

  // atan(1/3) scaled by 2^60; atan(1) = atan(1/2) + atan(1/3).
  function automatic longint atan_third();
    longint acc;
    longint p3;
    acc = 0;
    p3  = 3;
    for (int k = 0; p3 <= ONE60; k++) begin
      if (k % 2 == 0) acc = acc + (ONE60 / p3) / longint'(2 * k + 1);
      else            acc = acc - (ONE60 / p3) / longint'(2 * k + 1);
      p3 = p3 * 9;
    end
    return acc;
  endfunction

  function automatic longint round_scale(input longint v);
    return (v + (ONE60 >>> (FRACS + 1))) >>> (60 - FRACS);
  endfunction

  function automatic logic [WIDTH-2:0] atan_entry(input int idx);
    longint r;
    r = round_scale((idx == 0) ? atan_pow2(1) + atan_third() : atan_pow2(idx));
    return r[WIDTH-2:0];
  endfunction

  localparam logic signed [WIDTH-1:0] K_SEED = WIDTH'(longint'(0.6072529350 * (2.0 ** FRACS)));

`ifdef CORDIC_SEQ_QUADRANT_EN
  localparam longint QPI_S = atan_pow2(1) + atan_third();
  localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(round_scale(2 * QPI_S));
  localparam logic signed [WIDTH-1:0] PI      = WIDTH'(round_scale(4 * QPI_S));
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    accept;
  logic                    last;
  logic [4:0]              i;
  logic signed [WIDTH-1:0] x, y, z;
  logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic signed [WIDTH-1:0] z_load;
  logic                    fold_load;
  logic                    fold;
  logic [WIDTH-2:0]        atan_rom [0:31];

  for (genvar g = 0; g < 32; g++) begin : g_rom
    localparam logic [WIDTH-2:0] ENTRY = atan_entry(g);
    assign atan_rom[g] = ENTRY;
  end

  iteration #(.WIDTH(WIDTH)) u_stage (
    .x(x), .y(y), .z(z), .shift(i), .angle(atan_rom[i]),
    .x_next(x_nx), .y_next(y_nx), .z_next(z_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and neither depends on the peer's valid/ready.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    last       = (i == 5'(ITERS - 1));
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    z_load    = z_in;
    fold_load = 1'b0;
`ifdef CORDIC_SEQ_QUADRANT_EN
    if (z_in > HALF_PI) begin
      z_load    = z_in - PI;
      fold_load = 1'b1;
    end else if (z_in < -HALF_PI) begin
      z_load    = z_in + PI;
      fold_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      i     <= '0;
      fold  <= 1'b0;
      x_out <= '0;
      y_out <= '0;
    end else if (accept) begin
      x    <= K_SEED;
      y    <= '0;
      z    <= z_load;
      i    <= '0;
      fold <= fold_load;
    end else if (state == RUN) begin
      x <= x_nx;
      y <= y_nx;
      z <= z_nx;
      if (i != 5'd31) i <= i + 5'd1;
      // A folded angle was shifted by pi, so the final vector points the opposite way.
      if (last) begin
        x_out <= fold ? -x_nx : x_nx;
        y_out <= fold ? -y_nx : y_nx;
      end
    end
  end
endmodule

// File: doc/cordic_seq.md
# cordic_seq

Iterative (folded) rotation-mode CORDIC controller. It sequences a single shift-add micro-rotation stage (the team's `iteration` module) over `ITERS` cycles to compute cos/sin of a fixed-point angle. It owns the atan ROM, the gain-compensated seed, the iteration counter and the valid/ready handshakes. It sits between the angle source and downstream consumers wherever an area-cheap sin/cos unit is needed.

## Interface
- `FRACS`, 21, fractional bits of all data words
- `INTS`, 1, integer bits, excluding sign
- `WIDTH`, `INTS+FRACS+1`, signed word width
- `ITERS`, 16, micro-rotations per operation; legal range 10..31, because the stage shift index is 5 bits
- `clk` input 1: single clock, all logic on the rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: angle offered
- `in_ready` output 1: block can accept an angle
- `z_in` input WIDTH: signed angle, radians, Q`INTS`.`FRACS`
- `out_valid` output 1: result held on `x_out`/`y_out`
- `out_ready` input 1: consumer accepts the result
- `x_out` output WIDTH: signed cos(z_in), same format
- `y_out` output WIDTH: signed sin(z_in), same format
- `busy` output 1: high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE. Reset goes to IDLE.
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE). `busy` = (state!=IDLE).
- **IDLE:** on `in_valid && in_ready`:
  - load x=K, y=0, z=z_in', i=0.
  - go to RUN.
  - K = round(0.6072529350·2^FRACS); 1273502 at FRACS=21.
- **RUN:** each cycle, register the stage outputs into x/y/z and increment i.
  - Stage inputs are the current x/y/z, i, and atan_rom[i].
  - When the update for i==ITERS-1 is registered, go to DONE. The counter saturates and never wraps.
- **DONE:** `x_out`/`y_out` are driven from registers and stay stable while `out_ready` is low. On `out_ready`, go to IDLE.
- **atan ROM:** entry i = round(atan(2^-i)·2^FRACS), WIDTH-1 bits, unsigned. Entry 0 = 1647099 at FRACS=21.
- **Arithmetic:**
  - x/y/z are WIDTH bits, two's complement.
  - Shifts are arithmetic.
  - Overflow wraps silently; it cannot occur for legal inputs.
- **Ignored inputs:**
  - `in_valid` outside IDLE is ignored, and `z_in` is not sampled.
  - `out_ready` outside DONE is ignored.
- **Reset mid-operation:** `rst` in any state aborts the operation and discards it. Next cycle: state=IDLE, `out_valid`=0.

## Timing
- Reset values: `out_valid`=0, `busy`=0, `x_out`=0, `y_out`=0, i=0, state=IDLE. `in_ready`=1 on the first cycle after `rst` deasserts.
- Acceptance edge T0 → `out_valid` rises after edge T0+ITERS.
  - Latency is ITERS cycles.
  - Quadrant folding, when enabled, adds no cycle.
- DONE→IDLE transition happens on the edge where `out_ready` is sampled high. `in_ready` returns on the next cycle.
- Minimum initiation interval is ITERS+2 cycles (accept, ITERS runs, done/handshake). There is no overlap between operations.

## Configuration
- `CORDIC_SEQ_QUADRANT_EN` defined:
  - At capture, if z_in > π/2 (3294199 at FRACS=21), z_in' = z_in − π (6588397).
  - If z_in < −π/2, z_in' = z_in + π.
  - In both cases the fold is flagged, and a flagged result has `x_out`/`y_out` negated when DONE is entered.
  - Full input range ±(2^INTS) is valid.
- Undefined:
  - z_in' = z_in.
  - Only |z_in| ≤ π/2 is valid.
  - Outside that range the output is deterministic but unspecified.

## Test plan
- **Reset, then angle 0:** z_in=0 → after 16 cycles `out_valid`=1, x_out=2097152±64, y_out=0±64; `in_ready`=0 throughout RUN/DONE.
- **π/4:** z_in=1647099 → x_out = y_out = 1482910±64. **−π/6:** z_in=−1098066 → x_out=1816187±64, y_out=−1048576±64.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → outputs are stable, and `in_valid` pulses are not accepted. Raise `out_ready` → IDLE next cycle, `in_ready`=1.
- **Reset mid-run:** assert `rst` at RUN cycle 7 → next cycle `busy`=0, `out_valid`=0, `in_ready`=1. A new angle then completes normally in 16 cycles.
- **Back-to-back with `out_ready` tied high:** consecutive accepts occur exactly ITERS+2 cycles apart, and results come out in order.
- **With `CORDIC_SEQ_QUADRANT_EN`:** z_in=3984589 (1.9 rad) → x_out=−678003±64, y_out=1984536±64. Repeat with z_in=−3984589 → x_out=−678003±64, y_out=−1984536±64.
